fpu_add_arbiter: RTL
====================

Name: fpu_add_arbiter

Overview:
- Shares one combinational single-precision adder (inputs data1/data2; outputs result/overflow/underflow) among NUM_REQ requesters.
- Round-robin arbitration, operand capture, registered result, and a per-requester valid/ready response.
- Sits between issue logic and the shared `adder` instance; the adder's ports connect to this block's add_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8). Derived localparam ID_W = $clog2(NUM_REQ).

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accepted (one-hot or zero)
- req_data1  in  NUM_REQ*32  operand A; requester i at bits [32*i+31:32*i]
- req_data2  in  NUM_REQ*32  operand B; same packing
- resp_valid  out  NUM_REQ  result valid to the owning requester (one-hot or zero)
- resp_ready  in  NUM_REQ  per-requester result accept
- resp_result  out  32  sum, shared bus, qualified by resp_valid
- resp_overflow  out  1  overflow flag, qualified by resp_valid
- resp_underflow  out  1  underflow flag, qualified by resp_valid
- add_data1  out  32  operand A to shared adder
- add_data2  out  32  operand B to shared adder
- add_result  in  32  adder sum
- add_overflow  in  1  adder overflow
- add_underflow  in  1  adder underflow
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is synchronous on n_rst=0 at a clk edge. Values on reset:
  - state=IDLE; all outputs 0.
  - Operand, result and grant-id registers 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transaction discards it; no response is issued.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Select winner = first i with req_valid[i]=1, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready[winner]=1 combinationally, all other bits 0. No valid requests -> req_ready=0.
  - At the clock edge when a winner exists:
    - Latch its data1/data2 into op regs and its index into gid.
    - Set last_grant=winner; go to EXEC.
- EXEC (exactly 1 cycle): add_data1/add_data2 driven from op regs (driven from op regs in every state). At the end of the cycle, capture add_result/add_overflow/add_underflow into result regs; go to RESP.
- RESP:
  - resp_valid[gid]=1; resp_result/flags come from the result regs and are held stable.
  - Held until resp_ready[gid]=1 at a clock edge, then go to IDLE.
  - resp_ready bits of other requesters are ignored.
- Latency: request handshake at edge N -> resp_valid high in the cycle after edge N+1. Earliest response accept at edge N+2. Earliest next grant at edge N+3.
- Simultaneous requests are resolved only by round-robin order. A requester granted last has lowest priority next time.
- req_valid may drop before grant with no effect. A requester may raise req_valid while its own response is pending; it is considered at the next IDLE.
- Arithmetic is entirely in the external adder; this block never modifies operands or results. Flags pass through unchanged.

Optional Feature:
- Macro: FPU_ADD_ARB_STATS_EN.
- Defined:
  - Adds outputs txn_count (16-bit) and exc_count (16-bit), both reset to 0.
  - txn_count increments on each RESP->IDLE transition.
  - exc_count increments when that completed response had overflow or underflow set.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and their counters do not exist.

Test Plan:
- Single request: req 0 with data1=0x42C86666 (100.2), data2=0x42B50000 (90.5), real adder attached -> resp_valid[0] 2 cycles after accept; resp_result=0x433EB333; flags 0.
- Sign mix on req 2: 0x42C86666 + 0xC2B50000 -> resp_result=0x411B3333 (9.7) on resp_valid[2] only; resp_valid[0,1,3]=0.
- All 4 req_valid held high continuously, resp_ready tied 1 -> grant order 0,1,2,3,0; one accept every 3 cycles; each response routed to the correct requester.
- Backpressure: resp_ready[1]=0 for 5 cycles during RESP -> resp_valid[1] and resp_result held stable; req_ready stays 0; grant resumes the cycle after resp_ready[1]=1.
- Reset in EXEC: n_rst=0 for 1 cycle -> next cycle busy=0, resp_valid=0, all outputs 0; the next request is granted to requester 0 first.
- With FPU_ADD_ARB_STATS_EN, adder model forcing add_overflow=1 on 2 of 5 transactions -> txn_count=5, exc_count=2.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: round-robin arbiter sharing one combinational FP adder
// among NUM_REQ requesters. A granted request's operands are captured,
// presented to the adder for one cycle, and the registered sum is returned
// to the owning requester with a valid/ready handshake.
// Optional build macro FPU_ADD_ARB_STATS_EN adds txn_count/exc_count outputs.
module fpu_add_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_data1,
  input  logic [NUM_REQ*32-1:0]   req_data2,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [31:0]             resp_result,
  output logic                    resp_overflow,
  output logic                    resp_underflow,
  output logic [31:0]             add_data1,
  output logic [31:0]             add_data2,
  input  logic [31:0]             add_result,
  input  logic                    add_overflow,
  input  logic                    add_underflow,
  output logic                    busy
`ifdef FPU_ADD_ARB_STATS_EN
  ,
  output logic [15:0]             txn_count,
  output logic [15:0]             exc_count
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     op1;
  logic [31:0]     op2;
  logic [31:0]     res_val;
  logic            res_ovf;
  logic            res_unf;
  logic [ID_W-1:0] gid;
  logic [ID_W-1:0] last_grant;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand_id;
  int              cand_int;

  // The adder always sees the captured operands; results are held registers.
  assign add_data1      = op1;
  assign add_data2      = op2;
  assign resp_result    = res_val;
  assign resp_overflow  = res_ovf;
  assign resp_underflow = res_unf;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand_int = 0;
    cand_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_int = (int'(last_grant) + k) % NUM_REQ;
      cand_id  = cand_int[ID_W-1:0];
      if (!found && req_valid[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
  end

  // Accept is offered only while idle, and only to the round-robin winner.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Main transaction FSM: grant/capture, one adder cycle, hold response.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      op1        <= '0;
      op2        <= '0;
      res_val    <= '0;
      res_ovf    <= 1'b0;
      res_unf    <= 1'b0;
      gid        <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      resp_valid <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op1        <= req_data1[{winner, 5'b00000} +: 32];
            op2        <= req_data2[{winner, 5'b00000} +: 32];
            gid        <= winner;
            last_grant <= winner;
            state      <= EXEC;
            busy       <= 1'b1;
          end
        end
        EXEC: begin
          res_val    <= add_result;
          res_ovf    <= add_overflow;
          res_unf    <= add_underflow;
          resp_valid <= NUM_REQ'(1) << gid;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready[gid]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef FPU_ADD_ARB_STATS_EN
  // Saturating counters of completed responses and those carrying a flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      txn_count <= '0;
      exc_count <= '0;
    end else if (state == RESP && resp_ready[gid]) begin
      if (txn_count != 16'hFFFF) begin
        txn_count <= txn_count + 16'd1;
      end
      if ((res_ovf || res_unf) && exc_count != 16'hFFFF) begin
        exc_count <= exc_count + 16'd1;
      end
    end
  end
`endif

endmodule
